// File: rtl/axi_wr_issue.sv
// ============================================================================
// Module   : axi_wr_issue
// Brief    : Single-beat AXI write issue stage with outstanding-B tracking.
//            Optional macro AXI_WR_RESP_CHECK_EN adds the sticky wr_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_issue #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3,
  parameter int AXI_ID          = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_size,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
`ifdef AXI_WR_RESP_CHECK_EN
  output logic                    wr_err,
`endif
  output logic                    wr_empty,
  output logic                    wr_done
);

  localparam logic [CNT_WIDTH-1:0] c_max_out = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [3:0]           c_axi_id  = 4'(AXI_ID);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    AW_WAIT = 2'd2,
    W_WAIT  = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2:0]              r_size;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_bready;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_b_ok;

  assign req_ready = (r_state == IDLE) && (r_count < c_max_out) && !reset;
  assign w_accept  = req_valid && req_ready;
  // A B beat with nothing outstanding is a slave protocol error: ignore it.
  assign w_b_ok    = bvalid && r_bready && (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND: begin
        if (awready && wready) w_state_nxt = IDLE;
        else if (awready)      w_state_nxt = W_WAIT;
        else if (wready)       w_state_nxt = AW_WAIT;
      end
      AW_WAIT: if (awready) w_state_nxt = IDLE;
      W_WAIT:  if (wready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_size   <= '0;
      r_strb   <= '0;
      r_data   <= '0;
      r_count  <= '0;
      r_bready <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bready <= 1'b1;
      r_done   <= w_b_ok;
      if (w_accept) begin
        r_addr <= req_addr;
        r_size <= req_size;
        r_strb <= req_strb;
        r_data <= req_data;
      end
      if (w_accept && !w_b_ok)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_b_ok) r_count <= r_count - 1'b1;
    end
  end

`ifdef AXI_WR_RESP_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (bvalid && r_bready && ((bresp != 2'b00) || (bid != c_axi_id)))
      r_err <= 1'b1;
  end
  assign wr_err = r_err;
`else
  logic w_unused_b;
  assign w_unused_b = ^{bid, bresp};
`endif

  assign awid     = c_axi_id;
  assign awaddr   = r_addr;
  assign awlen    = 8'd0;
  assign awsize   = r_size;
  assign awburst  = 2'b01;
  assign awvalid  = (r_state == SEND) || (r_state == AW_WAIT);
  assign wid      = c_axi_id;
  assign wdata    = r_data;
  assign wstrb    = r_strb;
  assign wlast    = 1'b1;
  assign wvalid   = (r_state == SEND) || (r_state == W_WAIT);
  assign bready   = r_bready;
  assign wr_empty = (r_count == '0);
  assign wr_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_issue.sv
// ============================================================================
// Module   : tb_axi_wr_issue
// Brief    : Directed self-checking bench for axi_wr_issue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strb;
  logic [31:0] req_data;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        wr_empty;
  logic        wr_done;
`ifdef AXI_WR_RESP_CHECK_EN
  logic        wr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  axi_wr_issue dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_strb(req_strb), .req_data(req_data),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef AXI_WR_RESP_CHECK_EN
    .wr_err(wr_err),
`endif
    .wr_empty(wr_empty), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one request, then let the issue cycle complete with both readies high.
  task automatic one_write(input logic [31:0] a, input logic [31:0] d);
    req_addr = a; req_data = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = 3'd2;
    req_strb = 4'hF; req_data = '0; awready = 1'b0; wready = 1'b0;
    bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
    tick(); tick();
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_empty", wr_empty, 1);
    check("rst_done", wr_done, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    reset = 1'b0;
    tick();
    check("bready_up", bready, 1);
    check("req_ready_up", req_ready, 1);
    check("const_aw", {awid, awlen, awburst, wid, wlast}, {4'd1, 8'd0, 2'b01, 4'd1, 1'b1});

    // single write, slave always ready
    awready = 1'b1; wready = 1'b1;
    req_addr = 32'h1000; req_data = 32'hDEADBEEF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t1_valids", {awvalid, wvalid}, 2'b11);
    check("t1_awaddr", awaddr, 32'h1000);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_wstrb_size", {wstrb, awsize}, {4'hF, 3'd2});
    check("t1_empty", wr_empty, 0);
    check("t1_req_ready", req_ready, 0);
    tick();
    check("t1_valids_drop", {awvalid, wvalid}, 2'b00);
    check("t1_empty_hold", wr_empty, 0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("t1_done", wr_done, 1);
    check("t1_empty_after", wr_empty, 1);
    tick();
    check("t1_done_once", wr_done, 0);

    // W before AW
    awready = 1'b0; wready = 1'b1;
    req_addr = 32'h1000; req_data = 32'h12345678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t2_send", {awvalid, wvalid}, 2'b11);
    tick();
    check("t2_aw_wait", {awvalid, wvalid}, 2'b10);
    check("t2_awaddr", awaddr, 32'h1000);
    check("t2_req_ready", req_ready, 0);
    tick();
    check("t2_aw_hold", {awvalid, wvalid, req_ready}, 3'b100);
    check("t2_awaddr_stable", awaddr, 32'h1000);
    awready = 1'b1;
    tick();
    check("t2_idle", {awvalid, wvalid, req_ready}, 3'b001);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("t2_empty", wr_empty, 1);

    // outstanding limit
    for (int i = 0; i < 4; i++) one_write(32'h2000 + 32'(i * 4), 32'(i));
    req_valid = 1'b1;
    check("t3_full", req_ready, 0);
    tick();
    check("t3_full_hold", req_ready, 0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("t3_ready_after_b", req_ready, 1);
    check("t3_done", wr_done, 1);
    tick();
    req_valid = 1'b0;
    tick();
    check("t3_full_again", req_ready, 0);
    bvalid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t3_drain_partial", wr_empty, 0);
    tick();
    bvalid = 1'b0;
    check("t3_drained", wr_empty, 1);

    // simultaneous accept and B with two outstanding
    one_write(32'h3000, 32'hA);
    one_write(32'h3004, 32'hB);
    req_valid = 1'b1; bvalid = 1'b1;
    tick();
    req_valid = 1'b0; bvalid = 1'b0;
    check("t4_done", wr_done, 1);
    tick();
    bvalid = 1'b1;
    tick();
    check("t4_cnt1", wr_empty, 0);
    tick();
    bvalid = 1'b0;
    check("t4_cnt0", wr_empty, 1);
    // stray B with nothing outstanding
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("t4_stray_done", wr_done, 0);
    check("t4_stray_empty", wr_empty, 1);

    // reset while in AW_WAIT
    awready = 1'b0; wready = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("t5_aw_wait", {awvalid, wvalid}, 2'b10);
    reset = 1'b1;
    tick();
    check("t5_rst_valids", {awvalid, wvalid}, 2'b00);
    check("t5_rst_empty", wr_empty, 1);
    reset = 1'b0; awready = 1'b1;
    tick();
    check("t5_req_ready", req_ready, 1);

`ifdef AXI_WR_RESP_CHECK_EN
    check("t6_err_init", wr_err, 0);
    one_write(32'h4000, 32'h1);
    bresp = 2'b10; bvalid = 1'b1;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check("t6_err_set", wr_err, 1);
    one_write(32'h4004, 32'h2);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("t6_err_sticky", wr_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t6_err_clear", wr_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
